// File: rtl/wts_key_event_scheduler.sv
// Key-event scheduler: one pending key command per channel (A..E), issued as a
// one-cycle pulse when a six-slot rotation (0..4 channel slots, 5 no-op) reaches that channel.
module wts_key_event_scheduler (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_ch,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       cmd_error,
    output logic [2:0] active,
    output logic       ch_a_key_on,
    output logic       ch_a_key_release,
    output logic       ch_a_key_off,
    output logic       ch_b_key_on,
    output logic       ch_b_key_release,
    output logic       ch_b_key_off,
    output logic       ch_c_key_on,
    output logic       ch_c_key_release,
    output logic       ch_c_key_off,
    output logic       ch_d_key_on,
    output logic       ch_d_key_release,
    output logic       ch_d_key_off,
    output logic       ch_e_key_on,
    output logic       ch_e_key_release,
    output logic       ch_e_key_off,
    output logic [4:0] pending
);

    typedef enum logic [1:0] {
        OP_CANCEL      = 2'b00,
        OP_KEY_ON      = 2'b01,
        OP_KEY_RELEASE = 2'b10,
        OP_KEY_OFF     = 2'b11
    } op_e;

    localparam int         NUM_CH   = 5;
    localparam logic [2:0] NOP_SLOT = 3'd5;

    logic [2:0] active_q, active_d;
    logic       cmd_error_q, cmd_error_d;
    logic [4:0] key_on_q, key_on_d;
    logic [4:0] key_rel_q, key_rel_d;
    logic [4:0] key_off_q, key_off_d;
    op_e        op_q [NUM_CH];
    op_e        op_d [NUM_CH];
    logic       accept;

    // A release never weakens a stored key_on/key_off; on/off/cancel always win.
    function automatic op_e merge_op(input op_e cur, input op_e cmd);
        case (cmd)
            OP_CANCEL:      merge_op = OP_CANCEL;
            OP_KEY_RELEASE: merge_op = (cur == OP_KEY_ON || cur == OP_KEY_OFF) ? cur : OP_KEY_RELEASE;
            default:        merge_op = cmd;
        endcase
    endfunction

    assign cmd_ready = ~reset;
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        op_e merged;
        // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
        merged      = OP_CANCEL;
        key_on_d    = '0;
        key_rel_d   = '0;
        key_off_d   = '0;
        cmd_error_d = accept && (cmd_ch > 3'd4);

        if (!enable) begin
            active_d = NOP_SLOT;
        end else if (active_q >= NOP_SLOT) begin
            active_d = 3'd0;
        end else begin
            active_d = active_q + 3'd1;
        end

        // Merging before issuing gives the same-edge bypass for free.
        for (int n = 0; n < NUM_CH; n++) begin
            merged = op_q[n];
            if (accept && cmd_ch == 3'(n)) begin
                merged = merge_op(op_q[n], op_e'(cmd_op));
            end
            op_d[n] = merged;
            if (active_d == 3'(n)) begin
                op_d[n]      = OP_CANCEL;
                key_on_d[n]  = (merged == OP_KEY_ON);
                key_rel_d[n] = (merged == OP_KEY_RELEASE);
                key_off_d[n] = (merged == OP_KEY_OFF);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            active_q    <= NOP_SLOT;
            cmd_error_q <= 1'b0;
            key_on_q    <= '0;
            key_rel_q   <= '0;
            key_off_q   <= '0;
            // NOTE: the small per-channel op array is reset on purpose; reset must discard queued commands.
            for (int n = 0; n < NUM_CH; n++) begin
                op_q[n] <= OP_CANCEL;
            end
        end else begin
            active_q    <= active_d;
            cmd_error_q <= cmd_error_d;
            key_on_q    <= key_on_d;
            key_rel_q   <= key_rel_d;
            key_off_q   <= key_off_d;
            for (int n = 0; n < NUM_CH; n++) begin
                op_q[n] <= op_d[n];
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            pending[n] = (op_q[n] != OP_CANCEL);
        end
    end

    assign active    = active_q;
    assign cmd_error = cmd_error_q;

    assign ch_a_key_on      = key_on_q[0];
    assign ch_a_key_release = key_rel_q[0];
    assign ch_a_key_off     = key_off_q[0];
    assign ch_b_key_on      = key_on_q[1];
    assign ch_b_key_release = key_rel_q[1];
    assign ch_b_key_off     = key_off_q[1];
    assign ch_c_key_on      = key_on_q[2];
    assign ch_c_key_release = key_rel_q[2];
    assign ch_c_key_off     = key_off_q[2];
    assign ch_d_key_on      = key_on_q[3];
    assign ch_d_key_release = key_rel_q[3];
    assign ch_d_key_off     = key_off_q[3];
    assign ch_e_key_on      = key_on_q[4];
    assign ch_e_key_release = key_rel_q[4];
    assign ch_e_key_off     = key_off_q[4];

endmodule

// File: tb/tb_wts_key_event_scheduler.sv
// Bench for wts_key_event_scheduler: directed scenarios then random traffic, every
// cycle compared against a frame-count / per-channel-latest-command reference model.
module tb_wts_key_event_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cmd_valid;
    logic [2:0] cmd_ch;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       cmd_error;
    logic [2:0] active;
    logic       ch_a_key_on, ch_a_key_release, ch_a_key_off;
    logic       ch_b_key_on, ch_b_key_release, ch_b_key_off;
    logic       ch_c_key_on, ch_c_key_release, ch_c_key_off;
    logic       ch_d_key_on, ch_d_key_release, ch_d_key_off;
    logic       ch_e_key_on, ch_e_key_release, ch_e_key_off;
    logic [4:0] pending;

    int checks = 0;
    int errors = 0;

    // Reference model: slot is the count of consecutive enabled edges modulo 6.
    int         m_run;
    int         m_active;
    int         m_err;
    int         m_pend [5];
    logic [4:0] m_on, m_rel, m_off;

    wts_key_event_scheduler dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .cmd_valid        (cmd_valid),
        .cmd_ch           (cmd_ch),
        .cmd_op           (cmd_op),
        .cmd_ready        (cmd_ready),
        .cmd_error        (cmd_error),
        .active           (active),
        .ch_a_key_on      (ch_a_key_on),
        .ch_a_key_release (ch_a_key_release),
        .ch_a_key_off     (ch_a_key_off),
        .ch_b_key_on      (ch_b_key_on),
        .ch_b_key_release (ch_b_key_release),
        .ch_b_key_off     (ch_b_key_off),
        .ch_c_key_on      (ch_c_key_on),
        .ch_c_key_release (ch_c_key_release),
        .ch_c_key_off     (ch_c_key_off),
        .ch_d_key_on      (ch_d_key_on),
        .ch_d_key_release (ch_d_key_release),
        .ch_d_key_off     (ch_d_key_off),
        .ch_e_key_on      (ch_e_key_on),
        .ch_e_key_release (ch_e_key_release),
        .ch_e_key_off     (ch_e_key_off),
        .pending          (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0 cancel, 1 key_on, 2 key_release, 3 key_off
    function automatic int merge_ref(input int cur, input int cmd);
        if (cmd == 0) return 0;
        if (cmd == 2 && (cur == 1 || cur == 3)) return cur;
        return cmd;
    endfunction

    task automatic model_edge();
        bit acc;
        acc   = cmd_valid && !reset;
        m_err = (acc && cmd_ch > 3'd4) ? 1 : 0;
        m_on  = '0;
        m_rel = '0;
        m_off = '0;
        if (reset) begin
            m_run    = 0;
            m_active = 5;
            m_err    = 0;
            for (int i = 0; i < 5; i++) m_pend[i] = 0;
        end else begin
            if (!enable) begin
                m_run    = 0;
                m_active = 5;
            end else begin
                m_active = m_run % 6;
                m_run++;
            end
            if (acc && cmd_ch <= 3'd4) m_pend[cmd_ch] = merge_ref(m_pend[cmd_ch], int'(cmd_op));
            if (m_active < 5) begin
                case (m_pend[m_active])
                    1: m_on[m_active]  = 1'b1;
                    2: m_rel[m_active] = 1'b1;
                    3: m_off[m_active] = 1'b1;
                    default: ;
                endcase
                m_pend[m_active] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [4:0] pend_exp;
        logic [4:0] obs_on, obs_rel, obs_off;
        obs_on  = {ch_e_key_on, ch_d_key_on, ch_c_key_on, ch_b_key_on, ch_a_key_on};
        obs_rel = {ch_e_key_release, ch_d_key_release, ch_c_key_release, ch_b_key_release, ch_a_key_release};
        obs_off = {ch_e_key_off, ch_d_key_off, ch_c_key_off, ch_b_key_off, ch_a_key_off};
        for (int i = 0; i < 5; i++) pend_exp[i] = (m_pend[i] != 0);
        check("active", 32'(active), 32'(m_active));
        check("key_on", 32'(obs_on), 32'(m_on));
        check("key_release", 32'(obs_rel), 32'(m_rel));
        check("key_off", 32'(obs_off), 32'(m_off));
        check("pending", 32'(pending), 32'(pend_exp));
        check("cmd_error", 32'(cmd_error), 32'(m_err));
        check("cmd_ready", 32'(cmd_ready), 32'(!reset));
        checks++;
        assert ($countones({obs_on, obs_rel, obs_off}) <= 1) else begin
            errors++;
            $error("FAIL one_pulse observed=%0h expected=at_most_one", {obs_on, obs_rel, obs_off});
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [2:0] ch, input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_ch    = ch;
        cmd_op    = op;
        step();
        cmd_valid = 1'b0;
    endtask

    // Steps until the current cycle shows slot k; bounded by two frames.
    task automatic wait_active(input int k);
        int budget;
        budget = 0;
        while (m_active != k && budget < 12) begin
            step();
            budget++;
        end
        check("wait_active", 32'(active), 32'(k));
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        cmd_valid = 1'b0;
        cmd_ch    = 3'd0;
        cmd_op    = 2'b00;
        m_run     = 0;
        m_active  = 5;
        m_err     = 0;
        m_on      = '0;
        m_rel     = '0;
        m_off     = '0;
        for (int i = 0; i < 5; i++) m_pend[i] = 0;

        repeat (3) step();
        reset = 1'b0;
        repeat (60) step();

        // key_on ch A accepted while slot 2 is current
        wait_active(2);
        send(3'd0, 2'b01);
        repeat (8) step();

        // ch C: on then release -> on only; release then off -> off only
        wait_active(3);
        send(3'd2, 2'b01);
        send(3'd2, 2'b10);
        repeat (8) step();
        wait_active(3);
        send(3'd2, 2'b10);
        send(3'd2, 2'b11);
        repeat (8) step();

        // bypass: key_off ch E accepted on the edge that sets slot 4
        wait_active(3);
        send(3'd4, 2'b11);
        check("bypass_e_off", 32'(ch_e_key_off), 32'd1);
        check("bypass_e_pending", 32'(pending[4]), 32'd0);
        repeat (3) step();

        // freeze with key_on pending on B and D, then resume
        wait_active(2);
        send(3'd1, 2'b01);
        send(3'd3, 2'b01);
        enable = 1'b0;
        repeat (10) step();
        enable = 1'b1;
        repeat (8) step();

        // invalid channel, then reset with pending 10101
        send(3'd6, 2'b01);
        repeat (2) step();
        wait_active(2);
        send(3'd0, 2'b01);
        send(3'd2, 2'b11);
        send(3'd4, 2'b10);
        check("pending_10101", 32'(pending), 32'h15);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (12) step();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_ch    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            cmd_op    = 2'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wts_key_event_scheduler.md
WTS_KEY_EVENT_SCHEDULER -- requirements
Module: wts_key_event_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: enable  input  1  1 = time-slot rotation runs; 0 = frozen on no-op slot.
REQ-004 SHALL have port: cmd_valid  input  1  key command request strobe, one command per cycle.
REQ-005 SHALL have port: cmd_ch  input  3  target channel, 0..4 = A..E; 5..7 invalid.
REQ-006 SHALL have port: cmd_op  input  2  00 cancel, 01 key_on, 10 key_release, 11 key_off.
REQ-007 SHALL have port: cmd_ready  output  1  command acceptance; equals ~reset.
REQ-008 SHALL have port: cmd_error  output  1  one-cycle registered pulse when accepted command has cmd_ch > 4.
REQ-009 SHALL have port: active  output  3  registered slot index, 0..4 = channel slot, 5 = no operation; drives envelope generator.
REQ-010 SHALL have ports: ch_{a..e}_key_on, ch_{a..e}_key_release, ch_{a..e}_key_off  output  1 each  registered one-cycle key pulses (15 total).
REQ-011 SHALL have port: pending  output  5  bit n = channel n holds an unissued command.

Function
REQ-012 Slot counter SHALL sequence active 0,1,2,3,4,5,0,... advancing one step per clock while enable=1 (6-cycle frame).
REQ-013 While enable=0, active SHALL be loaded with 5 on each edge; on the first edge with enable=1, active SHALL become 0.
REQ-014 Command accepted on edge E when cmd_valid=1 and cmd_ready=1; cmd_ch 5..7 SHALL be dropped and SHALL assert cmd_error in the cycle after E.
REQ-015 Each channel SHALL hold one pending command register (op, 2 bits); op 00 = empty.
REQ-016 Merge rule on accept for channel n: key_on SHALL overwrite any pending op; key_off SHALL overwrite any pending op; key_release SHALL overwrite empty or key_release and SHALL be discarded if key_on or key_off pending; cancel SHALL clear pending.
REQ-017 On the edge that sets active to n (0..4), pending op of channel n SHALL be loaded into exactly one of ch_n key_on/release/off registers and pending[n] SHALL be cleared in the same edge.
REQ-018 Key pulse SHALL be high only during the cycle in which active==n; all 15 pulse registers SHALL be 0 in every other cycle, and at most one pulse is high per cycle.
REQ-019 Bypass: a command accepted on the same edge that sets active to n for its channel SHALL be merged with pending per REQ-016 and the merged result issued on that edge; pending[n] SHALL end 0.
REQ-020 Latency from accepting edge to pulse cycle SHALL be 0..5 cycles (pulse visible 1..6 cycles after cmd_valid cycle) with enable=1.
REQ-021 Pending commands SHALL be retained while enable=0 and issued in slot order after enable returns to 1.
REQ-022 Slot 5 SHALL issue no pulse and SHALL not alter any pending register except via new commands.

Reset
REQ-023 While reset=1: active=5, all key pulses 0, pending=0, all pending ops empty, cmd_error=0, cmd_ready=0; commands ignored.
REQ-024 Reset asserted mid-frame SHALL discard all pending commands; after release with enable=1, first edge SHALL set active=0.

Verification
REQ-025 Reset release, enable=1, no commands -> active cycles 0..5 repeatedly, all pulses 0 for 60 cycles, pending=0.
REQ-026 key_on to ch 0 accepted while active=2 -> pending[0]=1 for cycles active=3,4,5; ch_a_key_on=1 exactly in cycle active=0; pending[0]=0 afterwards.
REQ-027 ch 2: key_on then key_release before slot 2 -> single ch_c_key_on pulse, no release pulse; key_release then key_off -> single ch_c_key_off pulse.
REQ-028 key_off to ch 4 accepted on edge setting active=4 -> ch_e_key_off=1 in that cycle (bypass), pending[4]=0.
REQ-029 enable=0 with key_on pending on ch 1 and 3 -> active=5, no pulses; enable=1 -> ch_b_key_on at active=1, ch_d_key_on at active=3.
REQ-030 cmd_ch=6 accepted -> cmd_error=1 one cycle, pending unchanged; reset mid-frame with pending=5'b10101 -> pending=0, no pulses after release.
